gpu_result_drain: RTL and testbench
===================================

GPU_RESULT_DRAIN -- requirements
Module: gpu_result_drain

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of GPU result lanes.
REQ-002 SHALL have parameter DW, default 32, meaning result word width.
REQ-003 SHALL have parameter DEPTH, default 8, meaning output FIFO entries (power of two).
REQ-004 SHALL have port CLK  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port GPU_RES  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port HLT  input  1  halt; freezes output side.
REQ-007 SHALL have port lane_vld  input  LANES  per-lane result-valid, one-cycle pulse per group.
REQ-008 SHALL have port lane_res  input  LANES*DW  packed lane results, lane 0 in LSBs.
REQ-009 SHALL have port lane_rdy  output  1  capture register empty; group accepted this cycle.
REQ-010 SHALL have port out_vld  output  1  out_data/out_lane valid.
REQ-011 SHALL have port out_rdy  input  1  downstream accepts.
REQ-012 SHALL have port out_data  output  DW  result word at FIFO head.
REQ-013 SHALL have port out_lane  output  log2(LANES)  source lane of out_data.
REQ-014 SHALL have port fifo_cnt  output  log2(DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have port drop_err  output  1  sticky: a group arrived while lane_rdy low.

Function
REQ-016 Capture: when |lane_vld and lane_rdy, SHALL latch lane_res and lane_vld into capture register and pending bitmap on that edge.
REQ-017 lane_rdy SHALL be high iff pending bitmap is zero.
REQ-018 |lane_vld while lane_rdy low SHALL discard the whole group, leave capture untouched, set drop_err.
REQ-019 Serializer SHALL push one entry {lane index, word} per cycle, lowest set pending bit first, clearing that bit on push.
REQ-020 Serializer push SHALL occur iff pending nonzero and (fifo_cnt < DEPTH or pop this cycle).
REQ-021 Latency: group captured at edge N -> first entry pushed at edge N+1 -> out_vld high after edge N+1; k-lane group fully drained into FIFO by edge N+k.
REQ-022 lane_rdy SHALL rise after the edge that pushes the last pending bit; a new group may be captured the cycle lane_rdy is high.
REQ-023 out_vld SHALL equal (fifo_cnt != 0) and !HLT; out_data/out_lane SHALL present FIFO head (first-word fall-through).
REQ-024 Pop SHALL occur iff out_vld and out_rdy; head SHALL be stable while out_vld high and out_rdy low.
REQ-025 HLT high SHALL block pop and deassert out_vld; capture and serializer SHALL continue until FIFO full.
REQ-026 Simultaneous push and pop SHALL leave fifo_cnt unchanged, including at fifo_cnt == DEPTH.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH; fifo_cnt SHALL range 0..DEPTH.
REQ-028 Lane words SHALL pass through unmodified; lanes with lane_vld=0 SHALL produce no entry.

Reset
REQ-029 GPU_RES low SHALL asynchronously clear pending bitmap, pointers, fifo_cnt, drop_err; capture data need not reset.
REQ-030 Outputs during reset: lane_rdy=1, out_vld=0, out_data=0, out_lane=0, fifo_cnt=0, drop_err=0.
REQ-031 Reset mid-drain SHALL discard all pending and buffered entries; none SHALL appear after release.
REQ-032 Reset release SHALL be synchronised to CLK before use (async assert, sync deassert).

Structure
REQ-033 Shared GPU package SHALL hold LANES, DW default, and the {lane, word} entry record type.
REQ-034 FIFO SHALL be one sub-module, gpu_sync_fifo (parameterised DW+log2(LANES), DEPTH, FWFT, count output).
REQ-035 Capture register, pending bitmap and priority picker SHALL live in gpu_result_drain.

Verification
REQ-036 Group lane_vld=4'b1111, lane_res={15,11,7,3}, out_rdy=1 -> out (lane,data) = (0,3),(1,7),(2,11),(3,15) on four consecutive cycles starting the cycle after first push; lane_rdy low for 4 cycles.
REQ-037 Sparse group lane_vld=4'b1010, lanes1/3=0xA/0xC -> exactly (1,0xA),(3,0xC); lane_rdy back high after 2 pushes.
REQ-038 out_rdy=0, three full groups -> fifo_cnt saturates at 8, serializer stalls, lane_rdy low, 4 entries held; release out_rdy -> 12 entries in order, none lost.
REQ-039 Second group pulsed while lane_rdy low -> drop_err=1 sticky, output contains only first group.
REQ-040 HLT=1 with fifo_cnt=3 -> out_vld=0, no pops; HLT=0 -> same 3 entries drained in order.
REQ-041 GPU_RES low mid-drain (2 of 4 emitted) -> out_vld=0, fifo_cnt=0, lane_rdy=1 immediately; no stale entries after release.

Source files
------------

// File: rtl/gpu_result_drain_pkg.sv
// rtl/gpu_result_drain_pkg.sv - shared GPU result-drain widths and entry record
package gpu_result_drain_pkg;

    localparam int GPU_LANES = 4;
    localparam int GPU_DW    = 32;
    localparam int GPU_LW    = $clog2(GPU_LANES);

    // One serialized FIFO entry: source lane index above the result word.
    typedef struct packed {
        logic [GPU_LW-1:0] lane;
        logic [GPU_DW-1:0] word;
    } gpu_entry_t;

endpackage

// File: rtl/gpu_sync_fifo.sv
// rtl/gpu_sync_fifo.sv - single-clock first-word-fall-through FIFO with occupancy count
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers and count only)
//   push, push_data : write one entry; caller never pushes into a full FIFO without a pop
//   pop          : remove head; caller never pops an empty FIFO
//   head         : entry at the read pointer (valid while cnt != 0)
//   cnt          : occupancy 0..DEPTH
module gpu_sync_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage is not reset; only the bookkeeping decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/gpu_result_drain.sv
// rtl/gpu_result_drain.sv - captures a group of GPU lane results and serializes them into a FIFO
//
// Ports:
//   CLK       : clock
//   GPU_RES   : asynchronous active-low reset (release synchronised internally)
//   HLT       : halt; blocks pops and hides out_vld, capture/serialize continue
//   lane_vld  : per-lane valid pulse for one result group
//   lane_res  : packed lane results, lane 0 in the LSBs
//   lane_rdy  : capture register empty; a group presented now is accepted
//   out_vld / out_rdy / out_data / out_lane : FIFO head handshake
//   fifo_cnt  : FIFO occupancy
//   drop_err  : sticky, a group arrived while lane_rdy was low
module gpu_result_drain
    import gpu_result_drain_pkg::*;
#(
    parameter int LANES = GPU_LANES,
    parameter int DW    = GPU_DW,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     GPU_RES,
    input  logic                     HLT,
    input  logic [LANES-1:0]         lane_vld,
    input  logic [LANES*DW-1:0]      lane_res,
    output logic                     lane_rdy,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(LANES)-1:0] out_lane,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     drop_err
);
    localparam int LW = $clog2(LANES);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Reset asserts immediately, releases two clocks later in the CLK domain.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge CLK or negedge GPU_RES) begin
        if (!GPU_RES) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    logic [LANES*DW-1:0] cap_data;
    logic [LANES-1:0]    pending;
    logic [LANES-1:0]    pending_cleared;
    logic [LW-1:0]       pick_idx;
    logic [DW-1:0]       pick_word;
    logic                any_vld;
    logic                capture;
    logic                push;
    logic                pop;
    logic                fifo_nonempty;
    logic [LW+DW-1:0]    head;

    assign any_vld  = |lane_vld;
    assign lane_rdy = (pending == '0);
    assign capture  = any_vld && lane_rdy;

    // Priority picker: scanning downward leaves the lowest set bit selected.
    always_comb begin
        pick_idx        = '0;
        pending_cleared = pending;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_idx = i[LW-1:0];
            end
        end
        pending_cleared[pick_idx] = 1'b0;
    end

    assign pick_word = cap_data[int'(pick_idx)*DW +: DW];

    assign fifo_nonempty = (fifo_cnt != '0);
    assign out_vld       = fifo_nonempty && !HLT;
    assign pop           = out_vld && out_rdy;
    // A pop frees the slot this same edge, so a full FIFO still accepts a push.
    assign push          = (pending != '0) && ((fifo_cnt < DEPTH_C) || pop);

    // Capture data carries no reset; pending says which lanes are meaningful.
    always_ff @(posedge CLK) begin
        if (capture) begin
            cap_data <= lane_res;
        end
    end

    // Capture and push are exclusive: capture needs pending empty, push needs it non-empty.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            drop_err <= 1'b0;
        end else begin
            if (capture) begin
                pending <= lane_vld;
            end else if (push) begin
                pending <= pending_cleared;
            end
            if (any_vld && !lane_rdy) begin
                drop_err <= 1'b1;
            end
        end
    end

    gpu_sync_fifo #(
        .W     (LW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({pick_idx, pick_word}),
        .pop       (pop),
        .head      (head),
        .cnt       (fifo_cnt)
    );

    // Gate with occupancy so the unreset storage never shows on the outputs.
    assign out_data = fifo_nonempty ? head[DW-1:0]     : '0;
    assign out_lane = fifo_nonempty ? head[LW+DW-1:DW] : '0;

endmodule

// File: tb/tb_gpu_result_drain.sv
// tb/tb_gpu_result_drain.sv - self-checking bench for gpu_result_drain
module tb_gpu_result_drain;

    logic         CLK = 1'b0;
    logic         GPU_RES;
    logic         HLT;
    logic [3:0]   lane_vld;
    logic [127:0] lane_res;
    logic         lane_rdy;
    logic         out_vld;
    logic         out_rdy;
    logic [31:0]  out_data;
    logic [1:0]   out_lane;
    logic [3:0]   fifo_cnt;
    logic         drop_err;

    gpu_result_drain #(.LANES(4), .DW(32), .DEPTH(8)) dut (
        .CLK      (CLK),
        .GPU_RES  (GPU_RES),
        .HLT      (HLT),
        .lane_vld (lane_vld),
        .lane_res (lane_res),
        .lane_rdy (lane_rdy),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_lane (out_lane),
        .fifo_cnt (fifo_cnt),
        .drop_err (drop_err)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int npop  = 0;
    logic [33:0] q[$];
    logic [33:0] mon_e;

    typedef struct {
        logic [3:0]   vld;
        logic [127:0] res;
        int           exp_n;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_group(input logic [3:0] v, input logic [127:0] r, input bit keep);
        lane_vld = v;
        lane_res = r;
        if (keep) begin
            for (int i = 0; i < 4; i++) begin
                if (v[i]) q.push_back({i[1:0], r[i*32 +: 32]});
            end
        end
        tick();
        lane_vld = 4'b0000;
    endtask

    task automatic wait_rdy();
        for (int k = 0; k < 60 && !lane_rdy; k++) tick();
        chk("rdy_wait", {63'd0, lane_rdy}, 64'd1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 300 && !(q.size() == 0 && fifo_cnt == 0 && lane_rdy); k++) tick();
        chk("idle_wait", {63'd0, (q.size() == 0 && fifo_cnt == 0)}, 64'd1);
    endtask

    // Scoreboard: every accepted output must match the oldest expected entry.
    always @(negedge CLK) begin
        if (out_vld && out_rdy) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("out_lane", {62'd0, out_lane}, {62'd0, mon_e[33:32]});
                chk("out_data", {32'd0, out_data}, {32'd0, mon_e[31:0]});
            end
            npop++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int cnt;
        vecs[0] = '{4'b1111, {32'd15, 32'd11, 32'd7, 32'd3}, 4};
        vecs[1] = '{4'b1010, {32'hC, 32'hDEAD, 32'hA, 32'hBEEF}, 2};
        vecs[2] = '{4'b0001, {32'h1, 32'h2, 32'h3, 32'h1234_5678}, 1};
        vecs[3] = '{4'b1000, {32'hFFFF_FFFF, 32'h2, 32'h3, 32'h4}, 1};
        vecs[4] = '{4'b0110, {$urandom, $urandom, $urandom, $urandom}, 2};
        vecs[5] = '{4'b1111, {$urandom, $urandom, $urandom, $urandom}, 4};

        GPU_RES  = 1'b0;
        HLT      = 1'b0;
        lane_vld = 4'b0000;
        lane_res = '0;
        out_rdy  = 1'b1;
        tick();
        tick();
        chk("rst_lane_rdy", {63'd0, lane_rdy}, 64'd1);
        chk("rst_out_vld",  {63'd0, out_vld},  64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_out_lane", {62'd0, out_lane}, 64'd0);
        chk("rst_fifo_cnt", {60'd0, fifo_cnt}, 64'd0);
        chk("rst_drop_err", {63'd0, drop_err}, 64'd0);
        GPU_RES = 1'b1;
        repeat (3) tick();

        // Table: each group drains in lane order, lane_rdy low one cycle per set lane.
        for (int v = 0; v < 6; v++) begin
            wait_rdy();
            p0 = npop;
            drive_group(vecs[v].vld, vecs[v].res, 1'b1);
            cnt = 0;
            for (int k = 0; k < 20 && !lane_rdy; k++) begin
                cnt++;
                tick();
            end
            chk("rdy_low_cycles", 64'(cnt), 64'(vecs[v].exp_n));
            wait_idle();
            chk("entry_count", 64'(npop - p0), 64'(vecs[v].exp_n));
        end

        // First-entry latency: nothing visible after capture edge, lane 0 after the next.
        drive_group(4'b1111, {32'd15, 32'd11, 32'd7, 32'd3}, 1'b1);
        chk("lat_vld_n",    {63'd0, out_vld},  64'd0);
        chk("lat_rdy_n",    {63'd0, lane_rdy}, 64'd0);
        tick();
        chk("lat_vld_n1",   {63'd0, out_vld},  64'd1);
        chk("lat_lane_n1",  {62'd0, out_lane}, 64'd0);
        chk("lat_data_n1",  {32'd0, out_data}, 64'd3);
        wait_idle();

        // Backpressure: three groups against a blocked output.
        out_rdy = 1'b0;
        for (int g = 0; g < 3; g++) begin
            wait_rdy();
            drive_group(4'b1111, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end
        repeat (3) tick();
        chk("bp_fifo_full", {60'd0, fifo_cnt}, 64'd8);
        chk("bp_rdy_low",   {63'd0, lane_rdy}, 64'd0);
        chk("bp_out_vld",   {63'd0, out_vld},  64'd1);
        tick();
        chk("bp_fifo_hold", {60'd0, fifo_cnt}, 64'd8);
        p0 = npop;
        out_rdy = 1'b1;
        tick();
        chk("bp_full_pushpop", {60'd0, fifo_cnt}, 64'd8);
        wait_idle();
        chk("bp_entries", 64'(npop - p0), 64'd12);

        // Halt holds three entries, then they drain in order.
        HLT = 1'b1;
        drive_group(4'b0111, {32'h0, 32'h33, 32'h22, 32'h11}, 1'b1);
        repeat (5) tick();
        chk("hlt_cnt",  {60'd0, fifo_cnt}, 64'd3);
        chk("hlt_vld",  {63'd0, out_vld},  64'd0);
        tick();
        chk("hlt_hold", {60'd0, fifo_cnt}, 64'd3);
        p0 = npop;
        HLT = 1'b0;
        wait_idle();
        chk("hlt_entries", 64'(npop - p0), 64'd3);

        // Group arriving while busy is dropped and flagged.
        chk("drop_clear", {63'd0, drop_err}, 64'd0);
        p0 = npop;
        drive_group(4'b1111, {32'h44, 32'h43, 32'h42, 32'h41}, 1'b1);
        chk("drop_busy", {63'd0, lane_rdy}, 64'd0);
        drive_group(4'b1111, {32'h99, 32'h98, 32'h97, 32'h96}, 1'b0);
        chk("drop_set", {63'd0, drop_err}, 64'd1);
        wait_idle();
        chk("drop_sticky",  {63'd0, drop_err}, 64'd1);
        chk("drop_entries", 64'(npop - p0), 64'd4);

        // Reset mid-drain after two of four entries have left.
        p0 = npop;
        drive_group(4'b1111, {32'h5D, 32'h5C, 32'h5B, 32'h5A}, 1'b1);
        for (int k = 0; k < 20 && (npop - p0) < 2; k++) tick();
        chk("mid_two_out", 64'(npop - p0), 64'd2);
        GPU_RES = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_vld",  {63'd0, out_vld},  64'd0);
        chk("mid_rst_cnt",  {60'd0, fifo_cnt}, 64'd0);
        chk("mid_rst_rdy",  {63'd0, lane_rdy}, 64'd1);
        chk("mid_rst_data", {32'd0, out_data}, 64'd0);
        chk("mid_rst_drop", {63'd0, drop_err}, 64'd0);
        repeat (3) tick();
        GPU_RES = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("post_rst_no_vld", {63'd0, out_vld}, 64'd0);
        end

        // Fresh traffic after reset still works.
        drive_group(4'b0101, {32'h0, 32'h77, 32'h0, 32'h66}, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
